// File: rtl/ysyx_22050854_mem_stage_if.sv
// Data-memory port of the RV64 memory stage: req/gnt/rvalid handshake.
// master = pipeline stage, slave = memory.
interface ysyx_22050854_mem_stage_if #(
  parameter int XLEN   = 64,
  parameter int MASK_W = 8
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [MASK_W-1:0] dmem_wmask;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wdata, dmem_wmask,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wdata, dmem_wmask,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/ysyx_22050854_mem_stage.sv
// RV64 memory-access stage: load/store over req/gnt/rvalid, lane shift, extend.
// Optional: YSYX_22050854_MISALIGN_CHK_EN adds a misaligned-access trap output.
module ysyx_22050854_mem_stage #(
  parameter int XLEN   = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_RegWr,
  input  logic              ex_MemtoReg,
  ysyx_22050854_mem_stage_if.master dmem,
  output logic              out_valid,
  output logic [XLEN-1:0]   alu_out,
  output logic [XLEN-1:0]   mem_data,
  output logic [4:0]        rd,
  output logic              RegWr,
  output logic              MemtoReg
`ifdef YSYX_22050854_MISALIGN_CHK_EN
  ,
  output logic              misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              req_q, we_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              ov_q;
  logic [XLEN-1:0]   alu_out_q, mem_data_q;
  logic [4:0]        rd_q;
  logic              regwr_q, m2r_q;

  // transaction-private copies of the ex_* fields
  logic [XLEN-1:0]   a_q;
  logic [2:0]        f3_q;
  logic [4:0]        rdl_q;
  logic              rwl_q, m2l_q, ld_q;

  logic [2:0]        off;
  logic              mem_op;
  logic [XLEN-1:0]   wdata_d;
  logic [MASK_W-1:0] wmask_d;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ld_d;
  logic              done;
  logic [XLEN-1:0]   done_data;
  logic              mis;

  assign off    = ex_alu_out[2:0];
  assign mem_op = ex_MemRead | ex_MemWrite;

  always_comb begin
    wdata_d = '0;
    wmask_d = '0;
    unique case (ex_funct3[1:0])
      2'b00: begin
        wmask_d = MASK_W'(8'h01) << off;
        wdata_d = XLEN'(ex_store_data[7:0]) << {off, 3'b0};
      end
      2'b01: begin
        wmask_d = MASK_W'(8'h03) << off;
        wdata_d = XLEN'(ex_store_data[15:0]) << {off, 3'b0};
      end
      2'b10: begin
        wmask_d = MASK_W'(8'h0F) << off;
        wdata_d = XLEN'(ex_store_data[31:0]) << {off, 3'b0};
      end
      default: begin
        wmask_d = '1;
        wdata_d = ex_store_data;
      end
    endcase
  end

`ifdef YSYX_22050854_MISALIGN_CHK_EN
  assign mis = (ex_funct3[1:0] == 2'b01 && off[0])
             | (ex_funct3[1:0] == 2'b10 && |off[1:0])
             | (ex_funct3[1:0] == 2'b11 && |off);
`else
  assign mis = 1'b0;
`endif

  assign sh = dmem.dmem_rdata >> {a_q[2:0], 3'b0};

  always_comb begin
    ld_d = '0;
    unique case (f3_q)
      3'b000: ld_d = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001: ld_d = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010: ld_d = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b011: ld_d = dmem.dmem_rdata;
      3'b100: ld_d = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101: ld_d = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110: ld_d = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: ld_d = '0;
    endcase
  end

  always_comb begin
    done      = 1'b0;
    done_data = '0;
    if (state_q == S_REQ && dmem.dmem_gnt && !ld_q) begin
      done = 1'b1;
    end
    if (state_q == S_WAIT && dmem.dmem_rvalid) begin
      done      = 1'b1;
      done_data = ld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b1;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ov_q       <= 1'b0;
      alu_out_q  <= '0;
      mem_data_q <= '0;
      rd_q       <= '0;
      regwr_q    <= 1'b0;
      m2r_q      <= 1'b0;
      a_q        <= '0;
      f3_q       <= '0;
      rdl_q      <= '0;
      rwl_q      <= 1'b0;
      m2l_q      <= 1'b0;
      ld_q       <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_ready_q && in_valid) begin
            a_q   <= ex_alu_out;
            f3_q  <= ex_funct3;
            rdl_q <= ex_rd;
            rwl_q <= ex_RegWr;
            m2l_q <= ex_MemtoReg;
            ld_q  <= ex_MemRead;
            if (!mem_op || mis) begin
              // ALU op or trapped access: answer straight away
              ov_q       <= 1'b1;
              alu_out_q  <= ex_alu_out;
              mem_data_q <= '0;
              rd_q       <= ex_rd;
              regwr_q    <= ex_RegWr & ~mis;
              m2r_q      <= ex_MemtoReg;
              in_ready_q <= ~mem_op;
            end else begin
              state_q    <= S_REQ;
              in_ready_q <= 1'b0;
              req_q      <= 1'b1;
              we_q       <= ~ex_MemRead;
              addr_q     <= {ex_alu_out[XLEN-1:3], 3'b0};
              wdata_q    <= ex_MemRead ? '0 : wdata_d;
              wmask_q    <= ex_MemRead ? '0 : wmask_d;
            end
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ld_q ? S_WAIT : S_IDLE;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (done) begin
        ov_q       <= 1'b1;
        alu_out_q  <= a_q;
        mem_data_q <= done_data;
        rd_q       <= rdl_q;
        regwr_q    <= rwl_q;
        m2r_q      <= m2l_q;
      end
    end
  end

`ifdef YSYX_22050854_MISALIGN_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= state_q == S_IDLE && in_ready_q
             && in_valid && mem_op && mis;
    end
  end

  assign misalign_err = err_q;
`endif

  assign in_ready        = in_ready_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wmask = wmask_q;
  assign out_valid       = ov_q;
  assign alu_out         = alu_out_q;
  assign mem_data        = mem_data_q;
  assign rd              = rd_q;
  assign RegWr           = regwr_q;
  assign MemtoReg        = m2r_q;

endmodule

// File: tb/tb_ysyx_22050854_mem_stage.sv
// Bench for ysyx_22050854_mem_stage: directed cases plus random ops
// against a byte-lane reference model.
module tb_ysyx_22050854_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ex_alu_out, ex_store_data;
  logic        ex_MemRead, ex_MemWrite;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_RegWr, ex_MemtoReg;
  logic        out_valid;
  logic [63:0] alu_out, mem_data;
  logic [4:0]  rd;
  logic        RegWr, MemtoReg;
`ifdef YSYX_22050854_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  ysyx_22050854_mem_stage_if #(.XLEN(64), .MASK_W(8)) dmem_if ();

  ysyx_22050854_mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_MemRead    (ex_MemRead),
    .ex_MemWrite   (ex_MemWrite),
    .ex_funct3     (ex_funct3),
    .ex_rd         (ex_rd),
    .ex_RegWr      (ex_RegWr),
    .ex_MemtoReg   (ex_MemtoReg),
    .dmem          (dmem_if.master),
    .out_valid     (out_valid),
    .alu_out       (alu_out),
    .mem_data      (mem_data),
    .rd            (rd),
    .RegWr         (RegWr),
    .MemtoReg      (MemtoReg)
`ifdef YSYX_22050854_MISALIGN_CHK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3,
                                         input int o,
                                         input logic [63:0] d);
    logic [63:0] v;
    int n;
    v = '0;
    n = nbytes(f3[1:0]);
    if (f3 == 3'b111) return '0;
    if (n == 8) return d;
    for (int i = 0; i < n; i++)
      if (o + i < 8) v[8*i +: 8] = d[8*(o+i) +: 8];
    if (!f3[2])
      for (int b = 8*n; b < 64; b++) v[b] = v[8*n-1];
    return v;
  endfunction

  function automatic logic [7:0] m_mask(input logic [1:0] s, input int o);
    logic [7:0] m;
    int n;
    m = '0;
    n = nbytes(s);
    if (n == 8) return 8'hFF;
    for (int i = 0; i < n; i++)
      if (o + i < 8) m[o+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [1:0] s, input int o,
                                          input logic [63:0] d);
    logic [63:0] w;
    int n;
    w = '0;
    n = nbytes(s);
    if (n == 8) return d;
    for (int i = 0; i < n; i++)
      if (o + i < 8) w[8*(o+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic bit m_mis(input logic [1:0] s, input int o);
`ifdef YSYX_22050854_MISALIGN_CHK_EN
    return (o % nbytes(s)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic run_alu(input logic [63:0] v, input logic [4:0] r,
                         input bit rw, input bit m2r);
    wait_ready();
    in_valid = 1; ex_alu_out = v; ex_MemRead = 0; ex_MemWrite = 0;
    ex_rd = r; ex_RegWr = rw; ex_MemtoReg = m2r;
    @(negedge clk);
    in_valid = 0;
    chk("alu_ov", out_valid, 1);
    chk("alu_out", alu_out, v);
    chk("alu_md", mem_data, 0);
    chk("alu_rd", rd, r);
    chk("alu_rw", RegWr, rw);
    chk("alu_m2r", MemtoReg, m2r);
    chk("alu_rdy", in_ready, 1);
  endtask

  task automatic run_mem(input bit ld, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd,
                         input logic [4:0] r, input bit rw,
                         input logic [63:0] rdata, input int gd,
                         input int rvd);
    int o;
    logic [63:0] exp_md;
    o = int'(a[2:0]);
    exp_md = ld ? m_load(f3, o, rdata) : 64'd0;
    wait_ready();
    in_valid = 1; ex_alu_out = a; ex_store_data = sd;
    ex_MemRead = ld; ex_MemWrite = !ld; ex_funct3 = f3;
    ex_rd = r; ex_RegWr = rw; ex_MemtoReg = ld;
    @(negedge clk);
    in_valid = 0;
    if (m_mis(f3[1:0], o)) begin
      chk("mis_req", dmem_if.dmem_req, 0);
      chk("mis_ov", out_valid, 1);
`ifdef YSYX_22050854_MISALIGN_CHK_EN
      chk("mis_err", misalign_err, 1);
`endif
      chk("mis_rw", RegWr, 0);
      chk("mis_md", mem_data, 0);
      chk("mis_rdy", in_ready, 0);
      @(negedge clk);
      chk("mis_ov_drop", out_valid, 0);
      chk("mis_req2", dmem_if.dmem_req, 0);
      return;
    end
    chk("req", dmem_if.dmem_req, 1);
    chk("addr", dmem_if.dmem_addr, {a[63:3], 3'b0});
    chk("we", dmem_if.dmem_we, !ld);
    chk("rdy_busy", in_ready, 0);
    if (!ld) begin
      chk("wmask", dmem_if.dmem_wmask, m_mask(f3[1:0], o));
      chk("wdata", dmem_if.dmem_wdata, m_wdata(f3[1:0], o, sd));
    end
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("req_hold", dmem_if.dmem_req, 1);
      chk("addr_hold", dmem_if.dmem_addr, {a[63:3], 3'b0});
    end
    dmem_if.dmem_gnt = 1;
    if (ld && ($urandom % 2 == 1)) begin
      dmem_if.dmem_rvalid = 1;
      dmem_if.dmem_rdata = ~rdata;
    end
    @(negedge clk);
    dmem_if.dmem_gnt = 0;
    dmem_if.dmem_rvalid = 0;
    chk("req_drop", dmem_if.dmem_req, 0);
    if (ld) begin
      chk("wait_ov", out_valid, 0);
      for (int i = 0; i < rvd; i++) begin
        @(negedge clk);
        chk("wait_ov", out_valid, 0);
      end
      dmem_if.dmem_rvalid = 1;
      dmem_if.dmem_rdata = rdata;
      @(negedge clk);
      dmem_if.dmem_rvalid = 0;
    end
    chk("mem_ov", out_valid, 1);
    chk("mem_md", mem_data, exp_md);
    chk("mem_alu", alu_out, a);
    chk("mem_rd", rd, r);
    chk("mem_rw", RegWr, rw);
    chk("mem_m2r", MemtoReg, ld);
    chk("mem_rdy", in_ready, 0);
    @(negedge clk);
    chk("mem_ov_drop", out_valid, 0);
    chk("hold_md", mem_data, exp_md);
    chk("rdy_back", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0;
    ex_alu_out = 0; ex_store_data = 0;
    ex_MemRead = 0; ex_MemWrite = 0; ex_funct3 = 0;
    ex_rd = 0; ex_RegWr = 0; ex_MemtoReg = 0;
    dmem_if.dmem_gnt = 0; dmem_if.dmem_rvalid = 0;
    dmem_if.dmem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_req", dmem_if.dmem_req, 0);
    chk("rst_we", dmem_if.dmem_we, 0);
    chk("rst_addr", dmem_if.dmem_addr, 0);
    chk("rst_wdata", dmem_if.dmem_wdata, 0);
    chk("rst_wmask", dmem_if.dmem_wmask, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_alu", alu_out, 0);
    chk("rst_md", mem_data, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rw", RegWr, 0);
    chk("rst_m2r", MemtoReg, 0);
    rst_n = 1;
    @(negedge clk);

    // back-to-back ALU results
    in_valid = 1; ex_alu_out = 64'h5; ex_rd = 5'd3; ex_RegWr = 1;
    @(negedge clk);
    chk("b2b_ov0", out_valid, 1);
    chk("b2b_alu0", alu_out, 64'h5);
    chk("b2b_rdy", in_ready, 1);
    ex_alu_out = 64'h7;
    @(negedge clk);
    in_valid = 0;
    chk("b2b_ov1", out_valid, 1);
    chk("b2b_alu1", alu_out, 64'h7);
    chk("b2b_md", mem_data, 0);
    @(negedge clk);
    chk("b2b_drop", out_valid, 0);
    chk("b2b_hold", alu_out, 64'h7);

    run_mem(1, 3'b000, 64'h8000_0003, 0, 5'd10, 1,
            64'h0000_0000_8000_0000, 2, 1);
    chk("lb_lit", mem_data, 64'hFFFF_FFFF_FFFF_FF80);
    run_mem(1, 3'b110, 64'h8000_0004, 0, 5'd11, 1,
            64'hF234_5678_0000_0000, 0, 0);
    chk("lwu_lit", mem_data, 64'h0000_0000_F234_5678);
    run_mem(1, 3'b011, 64'h8000_0000, 0, 5'd12, 1,
            64'hF234_5678_0000_0000, 1, 2);
    chk("ld_lit", mem_data, 64'hF234_5678_0000_0000);
    run_mem(0, 3'b001, 64'h8000_0006, 64'h1234, 5'd0, 0, 0, 1, 0);

    // reset while waiting for read data
    wait_ready();
    in_valid = 1; ex_alu_out = 64'h8000_0010; ex_MemRead = 1;
    ex_MemWrite = 0; ex_funct3 = 3'b011; ex_RegWr = 1; ex_rd = 5'd7;
    @(negedge clk);
    in_valid = 0;
    dmem_if.dmem_gnt = 1;
    @(negedge clk);
    dmem_if.dmem_gnt = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_ov", out_valid, 0);
    chk("abort_alu", alu_out, 0);
    chk("abort_rw", RegWr, 0);
    chk("abort_req", dmem_if.dmem_req, 0);
    chk("abort_rdy", in_ready, 1);
    dmem_if.dmem_rvalid = 1;
    dmem_if.dmem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    dmem_if.dmem_rvalid = 0;
    chk("late_rv_ov", out_valid, 0);
    @(negedge clk);
    chk("late_rv_ov2", out_valid, 0);
    chk("late_rv_md", mem_data, 0);

`ifdef YSYX_22050854_MISALIGN_CHK_EN
    run_mem(1, 3'b010, 64'h8000_0002, 0, 5'd9, 1, 0, 0, 0);
`endif

    for (int t = 0; t < 200; t++) begin
      int kind;
      logic [63:0] a, d;
      kind = $urandom % 3;
      a = {32'h0, $urandom} | 64'h8000_0000;
      d = {$urandom, $urandom};
      case (kind)
        0: run_alu(d, 5'($urandom), 1'($urandom), 1'($urandom));
        1: run_mem(1, 3'($urandom), a, 0, 5'($urandom), 1'($urandom),
                   d, $urandom % 4, $urandom % 4);
        default: run_mem(0, {1'b0, 2'($urandom)}, a, d, 5'($urandom),
                         1'b0, 0, $urandom % 4, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
